// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: req/ack port, stall generation,
// byte/half/word lane handling, misalignment and timeout reporting.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [1:0]  MemSize_MEM,
  input  logic        MemSigned_MEM,
  input  logic [31:0] ALUData_MEM,
  input  logic [31:0] StoreData_MEM,
  output logic [31:0] MemData_MEM,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        ld_q, ld_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        acc;
  logic        mis;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] rd_fmt;

  assign acc = MemRead_MEM | MemWrite_MEM;
  assign mis = (MemSize_MEM == 2'b01 && ALUData_MEM[0])
             | (MemSize_MEM[1] && ALUData_MEM[1:0] != 2'b00);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = StoreData_MEM;
    case (MemSize_MEM)
      2'b00: begin
        be_c    = 4'b0001 << ALUData_MEM[1:0];
        wdata_c = {4{StoreData_MEM[7:0]}};
      end
      2'b01: begin
        be_c    = ALUData_MEM[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{StoreData_MEM[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = StoreData_MEM;
      end
    endcase
  end

  // Lane select uses the offset captured at launch, not the live address.
  assign rd_b = dmem_rdata[{off_q, 3'b000} +: 8];
  assign rd_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    rd_fmt = dmem_rdata;
    case (size_q)
      2'b00:   rd_fmt = {{24{sgn_q & rd_b[7]}}, rd_b};
      2'b01:   rd_fmt = {{16{sgn_q & rd_h[15]}}, rd_h};
      default: rd_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    ld_d       = ld_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    off_d      = off_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    mem_stall  = 1'b0;
    misaligned = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && mis) begin
          misaligned = 1'b1;
        end else if (acc) begin
          mem_stall = 1'b1;
          state_d   = S_ACCESS;
          cnt_d     = '0;
          data_d    = '0;
          err_d     = 1'b0;
          ld_d      = ~MemWrite_MEM;
          size_d    = MemSize_MEM;
          sgn_d     = MemSigned_MEM;
          off_d     = ALUData_MEM[1:0];
          req_d     = 1'b1;
          we_d      = MemWrite_MEM;
          addr_d    = {ALUData_MEM[31:2], 2'b00};
          be_d      = be_c;
          wdata_d   = wdata_c;
        end
      end
      S_ACCESS: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          data_d  = ld_q ? rd_fmt : 32'h0;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CntLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign MemData_MEM = (state_q == S_DONE) ? data_q : 32'h0;
  assign bus_err     = (state_q == S_DONE) && err_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table with a result scoreboard,
// plus timeout and mid-access reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_MEM, MemWrite_MEM;
  logic [1:0]  MemSize_MEM;
  logic        MemSigned_MEM;
  logic [31:0] ALUData_MEM, StoreData_MEM;
  logic [31:0] MemData_MEM;
  logic        mem_stall, misaligned, bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .MemSize_MEM(MemSize_MEM), .MemSigned_MEM(MemSigned_MEM),
    .ALUData_MEM(ALUData_MEM), .StoreData_MEM(StoreData_MEM),
    .MemData_MEM(MemData_MEM), .mem_stall(mem_stall),
    .misaligned(misaligned), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, sdata, rdata;
    int          lat;
    logic        mis, we;
    logic [3:0]  be;
    logic [31:0] wdata, data;
    logic        chk_wd;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] size,
      logic sgn, logic [31:0] addr, logic [31:0] sdata,
      logic [31:0] rdata, int lat, logic mis, logic we,
      logic [3:0] be, logic [31:0] wdata, logic [31:0] data,
      logic chk_wd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn;
    v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.lat = lat; v.mis = mis; v.we = we; v.be = be;
    v.wdata = wdata; v.data = data; v.chk_wd = chk_wd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    MemRead_MEM   = 1'b0;
    MemWrite_MEM  = 1'b0;
    MemSize_MEM   = 2'b00;
    MemSigned_MEM = 1'b0;
    ALUData_MEM   = 32'h0;
    StoreData_MEM = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    MemRead_MEM   = v.rd;
    MemWrite_MEM  = v.wr;
    MemSize_MEM   = v.size;
    MemSigned_MEM = v.sgn;
    ALUData_MEM   = v.addr;
    StoreData_MEM = v.sdata;
    dmem_ack      = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    string tag;
    tag = $sformatf("v%0d", idx);
    step();
    drive(v);
    @(negedge clk);
    if (v.mis) begin
      chk({tag, "_mis"}, 32'(misaligned), 32'd1);
      chk({tag, "_mis_stall"}, 32'(mem_stall), 32'd0);
      chk({tag, "_mis_data"}, MemData_MEM, 32'h0);
      chk({tag, "_mis_req"}, 32'(dmem_req), 32'd0);
      step();
      idle_in();
      @(negedge clk);
      chk({tag, "_mis_req2"}, 32'(dmem_req), 32'd0);
      return;
    end
    chk({tag, "_nomis"}, 32'(misaligned), 32'd0);
    stalls = int'(mem_stall);
    sb.push_back(v.data);
    step();
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
    chk({tag, "_be"}, 32'(dmem_be), 32'(v.be));
    chk({tag, "_we"}, 32'(dmem_we), 32'(v.we));
    if (v.chk_wd) chk({tag, "_wdata"}, dmem_wdata, v.wdata);
    for (int i = 0; i <= v.lat; i++) begin
      stalls += int'(mem_stall);
      if (i == v.lat) begin
        dmem_ack   = 1'b1;
        dmem_rdata = v.rdata;
      end
      step();
      if (i != v.lat) @(negedge clk);
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h5A5A_5A5A;
    idle_in();
    @(negedge clk);
    chk({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_done_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_done_berr"}, 32'(bus_err), 32'd0);
    chk({tag, "_stall_cyc"}, 32'(stalls), 32'(v.lat + 2));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: scoreboard empty, got %h", tag, MemData_MEM);
    end else begin
      chk({tag, "_data"}, MemData_MEM, sb.pop_front());
    end
    step();
    @(negedge clk);
    chk({tag, "_idle_data"}, MemData_MEM, 32'h0);
  endtask

  vec_t tbl[$];

  initial begin
    int n;
    tbl.push_back(mk(1,0,2'b10,0,32'h100,32'h0,32'hDEADBEEF,0,
                     0,0,4'b1111,32'h0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,0,2'b00,1,32'h103,32'h0,32'h80123456,0,
                     0,0,4'b1000,32'h0,32'hFFFFFF80,0));
    tbl.push_back(mk(1,0,2'b00,0,32'h103,32'h0,32'h80123456,0,
                     0,0,4'b1000,32'h0,32'h00000080,0));
    tbl.push_back(mk(0,1,2'b01,0,32'h102,32'h0000ABCD,32'hFFFFFFFF,0,
                     0,1,4'b1100,32'hABCDABCD,32'h0,1));
    tbl.push_back(mk(1,0,2'b01,1,32'h102,32'h0,32'h80123456,2,
                     0,0,4'b1100,32'h0,32'hFFFF8012,0));
    tbl.push_back(mk(1,0,2'b01,0,32'h100,32'h0,32'h80128456,0,
                     0,0,4'b0011,32'h0,32'h00008456,0));
    tbl.push_back(mk(0,1,2'b00,0,32'h101,32'h000000A5,32'h0,0,
                     0,1,4'b0010,32'hA5A5A5A5,32'h0,1));
    tbl.push_back(mk(0,1,2'b10,0,32'h104,32'h12345678,32'h0,1,
                     0,1,4'b1111,32'h12345678,32'h0,1));
    tbl.push_back(mk(1,1,2'b10,0,32'h108,32'h11223344,32'hFFFFFFFF,0,
                     0,1,4'b1111,32'h11223344,32'h0,1));
    tbl.push_back(mk(1,0,2'b00,0,32'h102,32'h0,32'h80123456,0,
                     0,0,4'b0100,32'h0,32'h00000012,0));
    tbl.push_back(mk(1,0,2'b00,1,32'h101,32'h0,32'h80123456,0,
                     0,0,4'b0010,32'h0,32'h00000034,0));
    tbl.push_back(mk(1,0,2'b11,1,32'h10C,32'h0,32'hCAFEF00D,0,
                     0,0,4'b1111,32'h0,32'hCAFEF00D,0));
    tbl.push_back(mk(1,0,2'b10,0,32'h101,32'h0,32'h0,0,
                     1,0,4'b0000,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,2'b01,0,32'h103,32'h0,32'h0,0,
                     1,0,4'b0000,32'h0,32'h0,0));

    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_data", MemData_MEM, 32'h0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Timeout: no ack, request must stay up for exactly TIMEOUT cycles.
    step();
    MemRead_MEM = 1'b1;
    MemSize_MEM = 2'b10;
    ALUData_MEM = 32'h200;
    @(negedge clk);
    chk("to_stall0", 32'(mem_stall), 32'd1);
    step();
    @(negedge clk);
    n = 0;
    while (dmem_req === 1'b1 && n < 10) begin
      n++;
      step();
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(n), 32'd4);
    chk("to_berr", 32'(bus_err), 32'd1);
    chk("to_data", MemData_MEM, 32'h0);
    chk("to_done_stall", 32'(mem_stall), 32'd0);
    idle_in();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("to_idle_req", 32'(dmem_req), 32'd0);
    chk("to_idle_berr", 32'(bus_err), 32'd0);
    chk("to_idle_data", MemData_MEM, 32'h0);
    step();
    @(negedge clk);
    chk("to_idle_req2", 32'(dmem_req), 32'd0);

    // Reset while an access is outstanding.
    step();
    MemRead_MEM = 1'b1;
    MemSize_MEM = 2'b10;
    ALUData_MEM = 32'h300;
    step();
    @(negedge clk);
    chk("rs_req_pre", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    idle_in();
    step();
    @(negedge clk);
    chk("rs_req", 32'(dmem_req), 32'd0);
    chk("rs_stall", 32'(mem_stall), 32'd0);
    chk("rs_berr", 32'(bus_err), 32'd0);
    chk("rs_mis", 32'(misaligned), 32'd0);
    chk("rs_data", MemData_MEM, 32'h0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rs_req_post", 32'(dmem_req), 32'd0);
    chk("rs_berr_post", 32'(bus_err), 32'd0);

    run_vec(tbl[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
